// File: rtl/pdp8l_iop_master.sv
// pdp8l_iop_master -- CPU-side IOT initiator for the PDP-8/L I/O bus.
//
// Runs one IOT instruction: drives ioopcode/cputodev with an iopstart strobe,
// waits SETTLE cycles, samples the wire-ORed device returns, then strobes
// iopstop and idles RELEASE cycles before pulsing done.
//
// Ports:
//   CLOCK, RESET          rising-edge clock, synchronous active-high reset
//   start/opcode/acin     request from the CPU sequencer (accepted when !busy)
//   busy/done/bad         status; done is a one-cycle pulse
//   acout/skip            IOT result, valid with done, held until next accept
//   iopstart/iopstop      one-cycle bus strobes (iopstop also held in reset)
//   ioopcode/cputodev     opcode and AC on the bus, START through STOP only
//   devtocpu/AC_CLEAR/IO_SKIP  OR-combined device returns
module pdp8l_iop_master #(
  parameter int SETTLE  = 4,
  parameter int RELEASE = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        start,
  input  logic [11:0] opcode,
  input  logic [11:0] acin,
  output logic        busy,
  output logic        done,
  output logic        bad,
  output logic [11:0] acout,
  output logic        skip,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  input  logic [11:0] devtocpu,
  input  logic        AC_CLEAR,
  input  logic        IO_SKIP
);

  localparam int MAXC = (SETTLE > RELEASE) ? SETTLE : RELEASE;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SETTLE, S_STOP, S_RELEASE, S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bad      <= 1'b0;
      acout    <= '0;
      skip     <= 1'b0;
      iopstart <= 1'b0;
      // Held high through reset so every device drops its returns.
      iopstop  <= 1'b1;
      ioopcode <= '0;
      cputodev <= '0;
    end else begin
      iopstart <= 1'b0;
      iopstop  <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        // DONE accepts a new request exactly like IDLE (back-to-back).
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          if (start) begin
            if (opcode[11:9] == 3'o6) begin
              r_state  <= S_START;
              busy     <= 1'b1;
              iopstart <= 1'b1;
              ioopcode <= opcode;
              cputodev <= acin;
            end else begin
              // Not an IOT: finish immediately without touching the bus.
              r_state <= S_DONE;
              done    <= 1'b1;
              bad     <= 1'b1;
              acout   <= acin;
              skip    <= 1'b0;
            end
          end
        end
        S_START: begin
          r_state <= S_SETTLE;
          r_cnt   <= CW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            // cputodev still holds the latched AC here; it is the AC latch.
            acout   <= (AC_CLEAR ? 12'd0 : cputodev) | devtocpu;
            skip    <= IO_SKIP;
            bad     <= 1'b0;
            iopstop <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          ioopcode <= '0;
          cputodev <= '0;
          r_cnt    <= CW'(RELEASE - 1);
          r_state  <= S_RELEASE;
        end
        S_RELEASE: begin
          if (r_cnt == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8l_iop_master.sv
// Self-checking bench for pdp8l_iop_master: scenario tasks compare every
// cycle against expectations derived from the cycle-timing rules.
module tb_pdp8l_iop_master;
  localparam int S = 4;
  localparam int R = 2;
  localparam int D = 3 + S + R;  // done cycle of a valid IOT

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0;
  logic [11:0] opcode = '0, acin = '0, devtocpu = '0;
  logic AC_CLEAR = 1'b0, IO_SKIP = 1'b0;
  logic busy, done, bad, skip, iopstart, iopstop;
  logic [11:0] acout, ioopcode, cputodev;

  int nerr = 0;
  int nchk = 0;
  logic [11:0] last_ac;
  logic        last_skip, last_bad;

  pdp8l_iop_master #(.SETTLE(S), .RELEASE(R)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .opcode(opcode), .acin(acin),
    .busy(busy), .done(done), .bad(bad), .acout(acout), .skip(skip),
    .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
    .cputodev(cputodev), .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR),
    .IO_SKIP(IO_SKIP)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic next_cycle();
    @(posedge CLOCK); #1;
  endtask

  task automatic bus_idle(input bit noise);
    devtocpu = noise ? 12'($urandom) : 12'd0;
    AC_CLEAR = noise ? 1'($urandom) : 1'b0;
    IO_SKIP  = noise ? 1'($urandom) : 1'b0;
  endtask

  // One request from IDLE; device returns are active in cycles 2..2+S only.
  task automatic run_op(input logic [11:0] op, ac, dev, input logic clr, skp,
                        input bit noise);
    bit good;
    int dc;
    logic e_st, e_sp, e_busy, e_done;
    logic [11:0] e_opc, e_ctd;
    good = (op[11:9] == 3'o6);
    dc = good ? D : 1;
    last_ac   = good ? ((clr ? 12'd0 : ac) | dev) : ac;
    last_skip = good ? skp : 1'b0;
    last_bad  = !good;
    for (int c = 0; c <= dc; c++) begin
      start = (c == 0);
      if (c == 0) begin opcode = op; acin = ac; end
      else if (noise) begin opcode = 12'($urandom); acin = 12'($urandom); end
      if (good && c >= 2 && c <= 2 + S) begin
        devtocpu = dev; AC_CLEAR = clr; IO_SKIP = skp;
      end else bus_idle(noise);
      @(negedge CLOCK);
      e_st   = good && c == 1;
      e_sp   = good && c == 2 + S;
      e_busy = good && c >= 1 && c <= 2 + S + R;
      e_done = (c == dc);
      e_opc  = (good && c >= 1 && c <= 2 + S) ? op : 12'd0;
      e_ctd  = (good && c >= 1 && c <= 2 + S) ? ac : 12'd0;
      nchk++; if (iopstart !== e_st) begin nerr++;
        $display("FAIL iopstart op=%o cyc=%0d got=%b exp=%b", op, c, iopstart, e_st); end
      nchk++; if (iopstop !== e_sp) begin nerr++;
        $display("FAIL iopstop op=%o cyc=%0d got=%b exp=%b", op, c, iopstop, e_sp); end
      nchk++; if (busy !== e_busy) begin nerr++;
        $display("FAIL busy op=%o cyc=%0d got=%b exp=%b", op, c, busy, e_busy); end
      nchk++; if (done !== e_done) begin nerr++;
        $display("FAIL done op=%o cyc=%0d got=%b exp=%b", op, c, done, e_done); end
      nchk++; if (ioopcode !== e_opc) begin nerr++;
        $display("FAIL ioopcode op=%o cyc=%0d got=%o exp=%o", op, c, ioopcode, e_opc); end
      nchk++; if (cputodev !== e_ctd) begin nerr++;
        $display("FAIL cputodev op=%o cyc=%0d got=%o exp=%o", op, c, cputodev, e_ctd); end
      if (c == dc) begin
        nchk++; if (acout !== last_ac) begin nerr++;
          $display("FAIL acout op=%o got=%o exp=%o", op, acout, last_ac); end
        nchk++; if (skip !== last_skip) begin nerr++;
          $display("FAIL skip op=%o got=%b exp=%b", op, skip, last_skip); end
        nchk++; if (bad !== last_bad) begin nerr++;
          $display("FAIL bad op=%o got=%b exp=%b", op, bad, last_bad); end
      end
      next_cycle();
    end
    start = 1'b0;
    bus_idle(1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0;
    next_cycle(); next_cycle();
    @(negedge CLOCK);
    nchk++; if ({busy, done, bad, skip, iopstart, iopstop} !== 6'b000001) begin nerr++;
      $display("FAIL reset_flags got=%b exp=000001", {busy, done, bad, skip, iopstart, iopstop}); end
    nchk++; if ({acout, ioopcode, cputodev} !== 36'd0) begin nerr++;
      $display("FAIL reset_data got=%o/%o/%o exp=0", acout, ioopcode, cputodev); end
    next_cycle();
    RESET = 1'b0;
    next_cycle();
    @(negedge CLOCK);
    nchk++; if (iopstop !== 1'b0) begin nerr++;
      $display("FAIL reset_release_iopstop got=%b exp=0", iopstop); end
    next_cycle();
  endtask

  task automatic test_directed();
    run_op(12'o6031, 12'o1234, 12'o0000, 1'b0, 1'b1, 1'b0);
    run_op(12'o6036, 12'o7777, 12'o0301, 1'b1, 1'b0, 1'b0);
    run_op(12'o6034, 12'o0100, 12'o0041, 1'b0, 1'b0, 1'b1);
    run_op(12'o5036, 12'o4321, 12'o0000, 1'b0, 1'b0, 1'b1);
  endtask

  // Results stay put while the bus is noisy and nothing is started.
  task automatic test_hold();
    for (int c = 0; c < 5; c++) begin
      bus_idle(1'b1);
      @(negedge CLOCK);
      nchk++; if ({acout, skip, bad, busy, done} !== {last_ac, last_skip, last_bad, 2'b00}) begin nerr++;
        $display("FAIL hold cyc=%0d got=%o/%b/%b/%b/%b exp=%o/%b/%b/0/0", c, acout, skip, bad,
                 busy, done, last_ac, last_skip, last_bad); end
      next_cycle();
    end
    bus_idle(1'b0);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 16; c++) begin
      start = (c == 0);
      if (c == 0) begin opcode = 12'o6031; acin = 12'o1234; end
      IO_SKIP = (c >= 2 && c <= 3);
      if (c == 3) RESET = 1'b1;
      if (c == 4) RESET = 1'b0;
      @(negedge CLOCK);
      if (c == 4) begin
        nchk++; if ({busy, iopstop, done} !== 3'b010 || ioopcode !== 12'd0 || cputodev !== 12'd0) begin
          nerr++;
          $display("FAIL reset_mid busy/iopstop/done=%b ioopcode=%o cputodev=%o exp 010/0/0",
                   {busy, iopstop, done}, ioopcode, cputodev); end
      end
      if (c == 5) begin
        nchk++; if (iopstop !== 1'b0) begin nerr++;
          $display("FAIL reset_mid_iopstop got=%b exp=0", iopstop); end
      end
      if (c >= 4) begin
        nchk++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++;
          $display("FAIL reset_mid_nodone cyc=%0d done=%b busy=%b exp 0/0", c, done, busy); end
      end
      next_cycle();
    end
    start = 1'b0; IO_SKIP = 1'b0;
    run_op(12'o6031, 12'o1234, 12'o0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [11:0] a1, a2, d1, d2, e;
    logic e_st, e_done, e_busy;
    a1 = 12'($urandom); a2 = 12'($urandom); d1 = 12'($urandom); d2 = 12'($urandom);
    for (int c = 0; c <= 2 * D; c++) begin
      start = (c != 2 * D);
      if (c == 0) begin opcode = 12'o6041; acin = a1; end
      else if (c == D) begin opcode = 12'o6042; acin = a2; end
      else begin opcode = 12'($urandom); acin = 12'($urandom); end
      devtocpu = (c >= 2 && c <= 2 + S) ? d1 : (c >= D + 2 && c <= D + 2 + S) ? d2 : 12'd0;
      AC_CLEAR = 1'b0;
      IO_SKIP  = (c >= D + 2 && c <= D + 2 + S);
      @(negedge CLOCK);
      e_st   = (c == 1 || c == D + 1);
      e_done = (c == D || c == 2 * D);
      e_busy = (c >= 1 && c < D) || (c >= D + 1 && c < 2 * D);
      nchk++; if ({iopstart, done, busy} !== {e_st, e_done, e_busy}) begin nerr++;
        $display("FAIL b2b cyc=%0d iopstart/done/busy got=%b exp=%b", c,
                 {iopstart, done, busy}, {e_st, e_done, e_busy}); end
      if (e_done) begin
        e = (c == D) ? (a1 | d1) : (a2 | d2);
        nchk++; if (acout !== e || skip !== (c != D)) begin nerr++;
          $display("FAIL b2b_result cyc=%0d acout=%o skip=%b exp=%o/%b", c, acout, skip, e, c != D); end
      end
      next_cycle();
    end
    start = 1'b0;
    bus_idle(1'b0);
  endtask

  task automatic test_random();
    logic [11:0] op;
    for (int n = 0; n < 16; n++) begin
      op = 12'($urandom);
      if ($urandom_range(0, 3) != 0) op[11:9] = 3'o6;
      run_op(op, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pdp8l_iop_master.md
# pdp8l_iop_master

CPU-side IOT initiator for the PDP-8/L I/O bus: it executes one IOT instruction against the bus that our device interfaces (teletype, etc.) respond to. The block drives the opcode, AC and start/stop strobes, waits a fixed settle time, samples the wire-ORed device returns (data, AC clear, skip), then releases the bus. It sits between the CPU sequencer and the OR-combined device bus, and produces the updated AC and skip result.

## Interface

Parameters:
- SETTLE, 4: cycles from the end of the iopstart cycle to the sample edge; minimum 1.
- RELEASE, 2: idle cycles after the iopstop cycle before done; minimum 1.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  request to run one IOT; accepted only when busy=0.
- opcode  in  12  IOT instruction, 6xxx octal.
- acin  in  12  AC value, latched when start is accepted.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- bad  out  1  last request was not an IOT; valid with done, held after.
- acout  out  12  resulting AC; valid with done and held until the next accept.
- skip  out  1  resulting skip; valid with done and held until the next accept.
- iopstart  out  1  one-cycle bus start strobe.
- iopstop  out  1  one-cycle bus release strobe.
- ioopcode  out  12  opcode on the bus.
- cputodev  out  12  AC on the bus.
- devtocpu  in  12  OR of device data returns.
- AC_CLEAR  in  1  OR of device AC-clear requests.
- IO_SKIP  in  1  OR of device skip requests.

## Operation

- States: IDLE, START, SETTLE, STOP, RELEASE, DONE.
- IDLE:
  - busy=0.
  - start with opcode[11:9]=3'o6: latch opcode and acin, busy=1, go to START.
  - start with any other opcode[11:9]: go to DONE with bad=1, acout=acin, skip=0; no bus strobes.
- START: iopstart=1 for this one cycle. ioopcode and cputodev carry the latched values from START through the end of STOP. Both are 0 in every other state.
- SETTLE: count SETTLE cycles.
  - On the edge ending the last SETTLE cycle, capture acout = (AC_CLEAR ? 0 : aclatched) | devtocpu and skip = IO_SKIP.
  - bad=0.
  - Go to STOP.
- STOP: iopstop=1 for one cycle.
- RELEASE: count RELEASE cycles, then go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle.
  - A start in this cycle is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Bus inputs are ignored in every state except the SETTLE sample edge.
- start while busy=1 is ignored and not queued.
- RESET (any state):
  - The next state is IDLE.
  - iopstart=0, ioopcode=0, cputodev=0, busy=0, done=0, bad=0, acout=0, skip=0.
  - iopstop=1 in every cycle following a reset-sampled edge, so devices drop their returns. It goes to 0 in the first cycle after RESET deasserts.
  - An interrupted operation produces no done.

## Timing

- Count start sampled high in cycle 0:
  - START is cycle 1.
  - SETTLE is cycles 2..1+SETTLE; the sample is on the edge ending cycle 1+SETTLE.
  - STOP is cycle 2+SETTLE.
  - RELEASE is the following RELEASE cycles.
  - done is in cycle 3+SETTLE+RELEASE; with defaults this is cycle 9.
- Bad opcode: done in cycle 1.
- Devices register their returns on the iopstart edge, so returns are stable from cycle 2 onward. They clear on the iopstop edge, so they are 0 by the first RELEASE cycle.
- Back-to-back: with start held high, a new START follows each DONE. The period is 3+SETTLE+RELEASE cycles.
- All outputs are registered; no combinational path from the bus inputs to the outputs.

## Test plan

- opcode=6031, acin=1234, device model asserts IO_SKIP from cycle 2 to cycle 6. Required: iopstart only in cycle 1, iopstop only in cycle 6, done in cycle 9, skip=1, acout=1234, bad=0.
- opcode=6036, acin=7777, model returns AC_CLEAR=1 and devtocpu=0301. Required: acout=0301, skip=0, ioopcode=6036 and cputodev=7777 during cycles 1-6, both 0 from cycle 7.
- opcode=6034, acin=0100, devtocpu=0041, AC_CLEAR=0. Required: acout=0141. Also: IO_SKIP/devtocpu pulsed while IDLE and in RELEASE has no effect on the results.
- opcode=5036 -> done in cycle 1, bad=1, acout=acin, skip=0, iopstart and iopstop never asserted.
- RESET asserted in cycle 3 -> cycle 4: busy=0, iopstop=1, ioopcode=0, no done ever. Release RESET; a new start of 6031 then completes normally 9 cycles later.
- start held high across two operations:
  - Second START in cycle 10 and second done in cycle 18.
  - start pulses during cycles 2-8 do not extend or restart the first operation.
